// File: rtl/hnf_pkg.sv
// hnf_pkg: types and constants shared across the HN-F request path.
//   reqflit_t            CHI REQ flit payload as seen at the RXREQ ingress.
//   OP_*                 REQ channel opcodes (6-bit).
//   slc_state_t          SLC line state encoding (shared with the lookup stage).
//   sf_state_t           Snoop-filter entry state encoding (shared with the lookup stage).
//   is_lcrd_return()     true when an opcode is a link-credit return.
package hnf_pkg;

   typedef struct packed {
      logic [47:0] addr;
      logic [2:0]  size;
      logic [5:0]  opcode;
      logic [7:0]  txn_id;
      logic [6:0]  src_id;
      logic [6:0]  tgt_id;
      logic [7:0]  return_txn_id;
      logic [6:0]  stash_nid_return_nid;
   } reqflit_t;

   localparam logic [5:0] OP_ReqLCrdReturn = 6'h00;
   localparam logic [5:0] OP_ReadShared    = 6'h01;
   localparam logic [5:0] OP_ReadClean     = 6'h02;
   localparam logic [5:0] OP_ReadOnce      = 6'h03;
   localparam logic [5:0] OP_ReadNoSnp     = 6'h04;
   localparam logic [5:0] OP_PCrdReturn    = 6'h05;
   localparam logic [5:0] OP_ReadUnique    = 6'h07;
   localparam logic [5:0] OP_CleanShared   = 6'h08;
   localparam logic [5:0] OP_CleanInvalid  = 6'h09;
   localparam logic [5:0] OP_MakeInvalid   = 6'h0A;
   localparam logic [5:0] OP_CleanUnique   = 6'h0B;
   localparam logic [5:0] OP_MakeUnique    = 6'h0C;
   localparam logic [5:0] OP_Evict         = 6'h0D;
   localparam logic [5:0] OP_WriteNoSnpFull = 6'h1D;
   localparam logic [5:0] OP_WriteUniqueFull = 6'h19;
   localparam logic [5:0] OP_WriteBackFull = 6'h1B;

   typedef enum logic [2:0] {
      SLC_I  = 3'd0,
      SLC_SC = 3'd1,
      SLC_UC = 3'd2,
      SLC_UD = 3'd3,
      SLC_SD = 3'd4
   } slc_state_t;

   typedef enum logic [1:0] {
      SF_I      = 2'd0,
      SF_SHARED = 2'd1,
      SF_UNIQUE = 2'd2
   } sf_state_t;

   function automatic logic is_lcrd_return(input logic [5:0] opcode);
      return opcode == OP_ReqLCrdReturn;
   endfunction

endpackage

// File: rtl/hnf_rxreq_pocq_if.sv
// hnf_rxreq_pocq_if: RXREQ ingress bundle plus the POCQ head/dequeue handshake.
//   rxreq_flitv/rxreq_flit        link layer -> queue, REQ flit
//   rxreq_lcrdv                   queue -> link layer, one L-credit per pulse
//   rxreq_pocq_first_entry/_v     queue -> lookup stage, oldest entry
//   rxreq_pocq_deq                lookup stage -> queue, head consumed
//   pocq_count/pocq_overflow_err  status
// slave is the queue side, master is the requester/consumer side.
interface hnf_rxreq_pocq_if #(parameter int CNT_W = 4);
   import hnf_pkg::*;

   logic             rxreq_flitv;
   reqflit_t         rxreq_flit;
   logic             rxreq_lcrdv;
   reqflit_t         rxreq_pocq_first_entry;
   logic             rxreq_pocq_entry_v;
   logic             rxreq_pocq_deq;
   logic [CNT_W-1:0] pocq_count;
   logic             pocq_overflow_err;

   modport slave (
      input  rxreq_flitv, rxreq_flit, rxreq_pocq_deq,
      output rxreq_lcrdv, rxreq_pocq_first_entry, rxreq_pocq_entry_v,
             pocq_count, pocq_overflow_err
   );

   modport master (
      output rxreq_flitv, rxreq_flit, rxreq_pocq_deq,
      input  rxreq_lcrdv, rxreq_pocq_first_entry, rxreq_pocq_entry_v,
             pocq_count, pocq_overflow_err
   );
endinterface

// File: rtl/hnf_sync_fifo.sv
// hnf_sync_fifo: single-clock FIFO, DEPTH entries of type T.
//   clk, rst   clock, asynchronous active-high reset (pointers/occupancy only)
//   wr_en      write wr_data at tail (ignored when full)
//   rd_en      pop head (ignored when empty)
//   rd_data    head entry, read straight from storage at rd_ptr
//   count      occupancy, empty/full flags
module hnf_sync_fifo #(
   parameter int  DEPTH = 8,
   parameter type T     = logic,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  T                 wr_data,
   input  logic             rd_en,
   output T                 rd_data,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             wr_ok, rd_ok;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;

   // DEPTH is a power of two, so pointer increments wrap for free.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (wr_ok) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (rd_ok) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({wr_ok, rd_ok})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage carries no reset; stale contents are never visible because
   // the consumer qualifies rd_data with occupancy.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_reg] <= wr_data;
   end

   assign rd_data = mem[rd_ptr_reg];
   assign count   = count_reg;

endmodule

// File: rtl/hnf_rxreq_pocq.sv
// hnf_rxreq_pocq: point-of-coherence request queue at the HN-F RXREQ ingress.
//   clk, rst  clock, asynchronous active-high reset
//   rxreq     slave side of hnf_rxreq_pocq_if:
//             in : rxreq_flitv, rxreq_flit, rxreq_pocq_deq
//             out: rxreq_lcrdv, rxreq_pocq_first_entry, rxreq_pocq_entry_v,
//                  pocq_count, pocq_overflow_err
// Grants L-credits while queue space not already promised remains, enqueues
// REQ flits in arrival order, swallows ReqLCrdReturn flits, and flags any
// flit that arrives without a credit or into a full queue.
module hnf_rxreq_pocq
   import hnf_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int LCRD_MAX = 4,
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   hnf_rxreq_pocq_if.slave       rxreq
);

   localparam int CRD_W = $clog2(LCRD_MAX + 1);

   logic [CRD_W-1:0] crd_out_reg, crd_out_next;
   logic             err_reg, err_next;
   logic             lcrdv;
   logic             consume, is_ret, enq, drop, deq;
   reqflit_t         head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty, fifo_full;

   // Every granted credit reserves a queue slot, so occupancy plus
   // outstanding credits never exceeds DEPTH and a credited flit always fits.
   assign lcrdv = ~rst
                  && (int'(fifo_count) + int'(crd_out_reg) < DEPTH)
                  && (int'(crd_out_reg) < LCRD_MAX);

   always_comb begin
      is_ret  = is_lcrd_return(rxreq.rxreq_flit.opcode);
      consume = rxreq.rxreq_flitv & (crd_out_reg != '0);
      enq     = consume & ~is_ret & ~fifo_full;
      drop    = rxreq.rxreq_flitv & ((crd_out_reg == '0) | (~is_ret & fifo_full));
      deq     = rxreq.rxreq_pocq_deq & ~fifo_empty;
      crd_out_next = crd_out_reg + CRD_W'(lcrdv) - CRD_W'(consume);
      err_next     = err_reg | drop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crd_out_reg <= '0;
         err_reg     <= 1'b0;
      end else begin
         crd_out_reg <= crd_out_next;
         err_reg     <= err_next;
      end
   end

   hnf_sync_fifo #(
      .DEPTH (DEPTH),
      .T     (reqflit_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (enq),
      .wr_data (rxreq.rxreq_flit),
      .rd_en   (deq),
      .rd_data (head),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Head is forced to zero when empty so the port never exposes stale storage.
   assign rxreq.rxreq_lcrdv            = lcrdv;
   assign rxreq.rxreq_pocq_first_entry = fifo_empty ? '0 : head;
   assign rxreq.rxreq_pocq_entry_v     = ~fifo_empty;
   assign rxreq.pocq_count             = fifo_count;
   assign rxreq.pocq_overflow_err      = err_reg;

   credit_invariant: assert property (@(posedge clk) disable iff (rst)
      (int'(fifo_count) + int'(crd_out_reg) <= DEPTH));

endmodule

// File: tb/tb_hnf_rxreq_pocq.sv
module tb_hnf_rxreq_pocq;
   import hnf_pkg::*;

   localparam int DEPTH    = 8;
   localparam int LCRD_MAX = 4;
   localparam int CNT_W    = 4;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   hnf_rxreq_pocq_if #(.CNT_W(CNT_W)) bus ();

   hnf_rxreq_pocq #(.DEPTH(DEPTH), .LCRD_MAX(LCRD_MAX), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .rxreq (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   reqflit_t m_q[$];
   int       m_crd = 0;
   bit       m_err = 1'b0;

   task automatic model_step();
      int pre;
      bit grant;
      bit cons;
      pre   = m_q.size();
      grant = (pre + m_crd < DEPTH) && (m_crd < LCRD_MAX);
      cons  = bus.rxreq_flitv && (m_crd > 0);
      if (bus.rxreq_flitv) begin
         if (m_crd == 0) m_err = 1'b1;
         else if (bus.rxreq_flit.opcode == 6'h00) begin end
         else if (pre == DEPTH) m_err = 1'b1;
         else m_q.push_back(bus.rxreq_flit);
      end
      if (bus.rxreq_pocq_deq && pre > 0) void'(m_q.pop_front());
      m_crd = m_crd + int'(grant) - int'(cons);
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_q.delete();
            m_crd = 0;
            m_err = 1'b0;
         end else begin
            model_step();
         end
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("cyc_lcrdv", 128'(bus.rxreq_lcrdv),
                  128'((m_q.size() + m_crd < DEPTH) && (m_crd < LCRD_MAX)));
            check("cyc_count", 128'(bus.pocq_count), 128'(m_q.size()));
            check("cyc_entry_v", 128'(bus.rxreq_pocq_entry_v), 128'(m_q.size() != 0));
            check("cyc_err", 128'(bus.pocq_overflow_err), 128'(m_err));
            if (m_q.size() != 0)
               check("cyc_first_entry", 128'(bus.rxreq_pocq_first_entry), 128'(m_q[0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic reqflit_t mk(input logic [5:0] op, input logic [7:0] txn, input logic [47:0] addr);
      reqflit_t f;
      f = '0;
      f.opcode = op;
      f.txn_id = txn;
      f.addr   = addr;
      f.size   = 3'd6;
      f.src_id = 7'h05;
      f.tgt_id = 7'h20;
      return f;
   endfunction

   task automatic step(input bit v, input reqflit_t f, input bit d);
      bus.rxreq_flitv    = v;
      bus.rxreq_flit     = f;
      bus.rxreq_pocq_deq = d;
      @(posedge clk);
      #2;
      bus.rxreq_flitv    = 1'b0;
      bus.rxreq_flit     = '0;
      bus.rxreq_pocq_deq = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   task automatic fill_to_full(input string name);
      int budget;
      budget = 0;
      while (m_q.size() < DEPTH && budget < 200) begin
         if (m_crd > 0) step(1'b1, mk(OP_ReadShared, 8'(m_q.size()), 48'h1000 + 48'(budget)), 1'b0);
         else idle(1);
         budget++;
      end
      check(name, 128'(m_q.size()), 128'(DEPTH));
   endtask

   initial begin
      logic [5:0] samples;
      int         sent;
      int         budget;
      int         grants;
      reqflit_t   f;

      rst = 1'b1;
      bus.rxreq_flitv    = 1'b0;
      bus.rxreq_flit     = '0;
      bus.rxreq_pocq_deq = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;

      // Reset release: four consecutive grants then silence.
      check("rst_count", 128'(bus.pocq_count), 128'(0));
      check("rst_entry_v", 128'(bus.rxreq_pocq_entry_v), 128'(0));
      check("rst_err", 128'(bus.pocq_overflow_err), 128'(0));
      for (int i = 0; i < 6; i++) begin
         samples[i] = bus.rxreq_lcrdv;
         step(1'b0, '0, 1'b0);
      end
      check("init_grants", 128'(samples), 128'(6'b001111));

      // Single ReadUnique.
      step(1'b1, mk(OP_ReadUnique, 8'h11, 48'h0000_1234_5670), 1'b0);
      check("ru_entry_v", 128'(bus.rxreq_pocq_entry_v), 128'(1));
      check("ru_addr", 128'(bus.rxreq_pocq_first_entry.addr), 128'(48'h0000_1234_5670));
      check("ru_txn", 128'(bus.rxreq_pocq_first_entry.txn_id), 128'(8'h11));
      check("ru_count", 128'(bus.pocq_count), 128'(1));
      check("ru_lcrdv", 128'(bus.rxreq_lcrdv), 128'(1));
      idle(1);
      check("ru_lcrdv_after", 128'(bus.rxreq_lcrdv), 128'(0));
      step(1'b0, '0, 1'b1);
      check("ru_drained", 128'(bus.pocq_count), 128'(0));

      // Eight flits with no dequeue.
      sent = 0;
      budget = 0;
      while (sent < 8 && budget < 200) begin
         if (m_crd > 0) begin
            step(1'b1, mk(OP_ReadShared, 8'(sent), 48'h2000 + 48'(sent * 64)), 1'b0);
            sent++;
         end else begin
            idle(1);
         end
         budget++;
      end
      check("fill8_sent", 128'(sent), 128'(8));
      grants = 0;
      for (int i = 0; i < 5; i++) begin
         grants += int'(bus.rxreq_lcrdv);
         idle(1);
      end
      check("full_no_grant", 128'(grants), 128'(0));
      check("full_count", 128'(bus.pocq_count), 128'(8));
      for (int i = 0; i < 8; i++) begin
         check("order_txn", 128'(bus.rxreq_pocq_first_entry.txn_id), 128'(i));
         step(1'b0, '0, 1'b1);
         if (i == 0) begin
            check("deq1_lcrdv", 128'(bus.rxreq_lcrdv), 128'(1));
            check("deq1_count", 128'(bus.pocq_count), 128'(7));
            idle(1);
            check("deq1_lcrdv_once", 128'(bus.rxreq_lcrdv), 128'(0));
         end
      end
      check("drain_count", 128'(bus.pocq_count), 128'(0));

      // Credit return is absorbed and re-granted.
      idle(4);
      step(1'b1, mk(OP_ReadUnique, 8'h55, 48'h3000), 1'b0);
      idle(2);
      check("ret_pre_lcrdv", 128'(bus.rxreq_lcrdv), 128'(0));
      step(1'b1, mk(OP_ReqLCrdReturn, 8'h00, 48'h0), 1'b0);
      check("ret_count", 128'(bus.pocq_count), 128'(1));
      check("ret_entry_v", 128'(bus.rxreq_pocq_entry_v), 128'(1));
      check("ret_regrant", 128'(bus.rxreq_lcrdv), 128'(1));

      // Simultaneous enqueue and dequeue at occupancy 1.
      step(1'b1, mk(OP_ReadUnique, 8'h66, 48'h4000), 1'b1);
      check("swap_count", 128'(bus.pocq_count), 128'(1));
      check("swap_txn", 128'(bus.rxreq_pocq_first_entry.txn_id), 128'(8'h66));
      step(1'b0, '0, 1'b1);

      // Randomised legal traffic.
      for (int i = 0; i < 2000; i++) begin
         bit v;
         bit d;
         logic [5:0] op;
         v  = (m_crd > 0) && ($urandom_range(0, 2) != 0);
         d  = ($urandom_range(0, 1) == 1);
         op = ($urandom_range(0, 7) == 0) ? OP_ReqLCrdReturn : 6'($urandom_range(1, 63));
         f  = mk(op, 8'($urandom), {16'($urandom), 32'($urandom)});
         f.return_txn_id = 8'($urandom);
         f.stash_nid_return_nid = 7'($urandom);
         step(v, f, d);
      end

      // Flit with no credit outstanding.
      budget = 0;
      while (m_q.size() != 0 && budget < 50) begin
         step(1'b0, '0, 1'b1);
         budget++;
      end
      fill_to_full("ovf_fill");
      idle(2);
      step(1'b1, mk(OP_ReadUnique, 8'hEE, 48'h5000), 1'b0);
      check("ovf_err", 128'(bus.pocq_overflow_err), 128'(1));
      check("ovf_count", 128'(bus.pocq_count), 128'(8));
      idle(3);
      check("ovf_sticky", 128'(bus.pocq_overflow_err), 128'(1));

      // Asynchronous reset mid-stream.
      rst = 1'b1;
      #1;
      check("arst_lcrdv", 128'(bus.rxreq_lcrdv), 128'(0));
      check("arst_count", 128'(bus.pocq_count), 128'(0));
      check("arst_entry_v", 128'(bus.rxreq_pocq_entry_v), 128'(0));
      check("arst_err", 128'(bus.pocq_overflow_err), 128'(0));
      check("arst_first", 128'(bus.rxreq_pocq_first_entry), 128'(0));
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rerel_lcrdv", 128'(bus.rxreq_lcrdv), 128'(1));
      check("rerel_count", 128'(bus.pocq_count), 128'(0));
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hnf_rxreq_pocq.md
Name: hnf_rxreq_pocq

Overview:
Point-of-coherence request queue at the HN-F RXREQ ingress. It sits directly upstream of the SLC/SF lookup stage.
- Accepts CHI REQ flits from the link layer under L-credit flow control and holds them in arrival order.
- Presents the oldest entry as rxreq_pocq_first_entry/rxreq_pocq_entry_v.
- Retires that entry when the downstream stage asserts rxreq_pocq_deq.
- Link-credit returns (ReqLCrdReturn) are absorbed here and never reach the lookup stage.

Parameters:
DEPTH, 8, number of queue entries (power of two, >=2).
LCRD_MAX, 4, maximum L-credits outstanding to the requester (1..15, CHI limit).
CNT_W, $clog2(DEPTH+1), width of occupancy counter.

Ports:
clk  input  1  single clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
rxreq_flitv  input  1  REQ flit valid; legal only against a previously granted credit.
rxreq_flit  input  reqflit_t  REQ flit payload (Addr[47:0], Size, Opcode[5:0], TxnID, SrcID, TgtID, ReturnTxnID, StashNID_ReturnNID).
rxreq_lcrdv  output  1  one-cycle pulse = one L-credit granted to requester.
rxreq_pocq_first_entry  output  reqflit_t  oldest queued flit; registered.
rxreq_pocq_entry_v  output  1  first_entry is valid.
rxreq_pocq_deq  input  1  downstream consumed first_entry this cycle.
pocq_count  output  CNT_W  current occupancy.
pocq_overflow_err  output  1  sticky: flit arrived with no credit outstanding, or arrived while queue full.

Behaviour:
- Reset values: all outputs 0, rd_ptr = wr_ptr = 0, occupancy = 0, credits outstanding (crd_out) = 0, error flag cleared.
- Reset asserted mid-operation discards all entries and credits immediately (async). The requester is expected to be reset too.
- Credit grant: rxreq_lcrdv = 1 in a cycle iff (occupancy + crd_out) < DEPTH and crd_out < LCRD_MAX and rst = 0.
  - Evaluated on registered values.
  - At most one grant per cycle.
  - First grant occurs in the first clock after reset deassertion.
- crd_out_next = crd_out + lcrdv - (rxreq_flitv & crd_out != 0).
- Flit arrival (rxreq_flitv = 1, crd_out > 0):
  - Opcode == OP_ReqLCrdReturn (6'h00): credit consumed, nothing enqueued, occupancy unchanged. The freed credit becomes re-grantable next cycle.
  - Otherwise: flit written at wr_ptr, wr_ptr++ (wraps modulo DEPTH), occupancy++.
- Arrival with crd_out == 0, or a non-return flit when occupancy == DEPTH: flit dropped, pocq_overflow_err set (sticky until reset), counters unchanged.
- Dequeue: rxreq_pocq_deq with entry_v = 1 increments rd_ptr (wrap) and decrements occupancy. rxreq_pocq_deq with entry_v = 0 is ignored.
- Simultaneous enqueue and dequeue: occupancy unchanged, both pointers advance.
  - At occupancy 1, first_entry shows the new flit next cycle.
  - At occupancy DEPTH, enqueue cannot legally coincide; the credit invariant prevents it.
- Latency: a flit accepted in cycle N is visible as first_entry/entry_v = 1 in cycle N+1 if the queue was empty (no combinational bypass).
- first_entry = storage[rd_ptr]; entry_v = (occupancy != 0). Both are stable while not dequeued; downstream may sample over multiple cycles.
- Invariant: occupancy + crd_out <= DEPTH at all times. Assert in simulation.
- Order strictly FIFO; no address-hazard reordering in this block.

Decomposition:
- hnf_pkg holds: reqflit_t, OP_ReqLCrdReturn, OP_ReadUnique and other REQ opcodes, and the SF/SLC state encodings already shared with the lookup stage.
- One sub-module, hnf_sync_fifo (DEPTH, payload type): storage array, pointers, occupancy.
- hnf_rxreq_pocq wraps it with credit-counter logic, opcode filtering and the error flag.

Test Plan:
- Reset release, no traffic -> rxreq_lcrdv pulses in 4 consecutive cycles (LCRD_MAX = 4), then stays 0; entry_v = 0, pocq_count = 0.
- One ReadUnique flit, Addr = 48'h0000_1234_5670, TxnID = 8'h11 -> next cycle entry_v = 1, first_entry.Addr = 48'h0000_1234_5670, count = 1, one new lcrdv pulse.
- 8 flits with no deq -> count = 8, total grants stop at 8 (no lcrdv until deq). One deq -> exactly one lcrdv the following cycle; TxnIDs emerge 0..7 in order across pointer wrap.
- ReqLCrdReturn flit (Opcode 6'h00) -> count unchanged, entry_v unchanged, credit re-granted next cycle.
- Count = 1 (TxnID A), enqueue TxnID B with deq the same cycle -> count stays 1, first_entry.TxnID = B next cycle.
- Flit driven with crd_out = 0 -> dropped, pocq_overflow_err = 1 and stays 1. Assert rst mid-stream -> all outputs 0 immediately, grants restart after release.
